// File: rtl/slv_outstanding_txn_limiter.sv
// Outstanding-transaction limiter between the slave-side CDC output and the AXI slave port.
// Optional status outputs are enabled with `define SLV_TXN_LIMIT_STATS_EN.
module slv_outstanding_txn_limiter #(
  parameter int AWCHAN_WIDTH       = 64,
  parameter int ARCHAN_WIDTH       = 64,
  parameter int WCHAN_WIDTH        = 37,
  parameter int RCHAN_WIDTH        = 38,
  parameter int BCHAN_WIDTH        = 3,
  parameter int MAX_WR_OUTSTANDING = 4,
  parameter int MAX_RD_OUTSTANDING = 4
) (
  input  logic                    SLV_CLK,
  input  logic                    sysReset,
  input  logic                    DRAIN_REQ,
  output logic                    DRAIN_ACK,
  input  logic [AWCHAN_WIDTH-1:0] upAWPAYLOAD,
  input  logic                    upAWVALID,
  output logic                    upAWREADY,
  output logic [AWCHAN_WIDTH-1:0] dnAWPAYLOAD,
  output logic                    dnAWVALID,
  input  logic                    dnAWREADY,
  input  logic [WCHAN_WIDTH-1:0]  upWPAYLOAD,
  input  logic                    upWLAST,
  input  logic                    upWVALID,
  output logic                    upWREADY,
  output logic [WCHAN_WIDTH-1:0]  dnWPAYLOAD,
  output logic                    dnWLAST,
  output logic                    dnWVALID,
  input  logic                    dnWREADY,
  input  logic [BCHAN_WIDTH-1:0]  dnBPAYLOAD,
  input  logic                    dnBVALID,
  output logic                    dnBREADY,
  output logic [BCHAN_WIDTH-1:0]  upBPAYLOAD,
  output logic                    upBVALID,
  input  logic                    upBREADY,
  input  logic [ARCHAN_WIDTH-1:0] upARPAYLOAD,
  input  logic                    upARVALID,
  output logic                    upARREADY,
  output logic [ARCHAN_WIDTH-1:0] dnARPAYLOAD,
  output logic                    dnARVALID,
  input  logic                    dnARREADY,
  input  logic [RCHAN_WIDTH-1:0]  dnRPAYLOAD,
  input  logic                    dnRLAST,
  input  logic                    dnRVALID,
  output logic                    dnRREADY,
  output logic [RCHAN_WIDTH-1:0]  upRPAYLOAD,
  output logic                    upRLAST,
  output logic                    upRVALID,
  input  logic                    upRREADY,
  output logic [7:0]              STAT_WRCNT,
  output logic [7:0]              STAT_RDCNT,
  output logic                    STAT_ERR
);

  localparam logic [7:0] WR_LIMIT = 8'(MAX_WR_OUTSTANDING);
  localparam logic [7:0] RD_LIMIT = 8'(MAX_RD_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_QUIESCED = 2'd2
  } state_t;

  state_t     state_q;
  logic       drain_ack_q;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic [7:0] aw_pend_q, aw_pend_d;

  logic aw_ok_s, ar_ok_s, w_ok_s, idle_s;
  logic aw_hs_s, w_last_hs_s, b_hs_s, ar_hs_s, r_last_hs_s;

  // A decrement at zero saturates; a simultaneous increment and decrement cancel.
  function automatic logic [7:0] cnt_next(input logic [7:0] cnt, input logic inc, input logic dec);
    logic [7:0] res;
    case ({inc, dec})
      2'b10:   res = cnt + 8'd1;
      2'b01:   res = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
      default: res = cnt;
    endcase
    return res;
  endfunction

  assign aw_ok_s = (wr_cnt_q < WR_LIMIT) && (state_q == ST_RUN);
  assign ar_ok_s = (rd_cnt_q < RD_LIMIT) && (state_q == ST_RUN);
  assign w_ok_s  = (aw_pend_q != 8'd0);
  assign idle_s  = (wr_cnt_q == 8'd0) && (rd_cnt_q == 8'd0) && (aw_pend_q == 8'd0);

  assign dnAWPAYLOAD = upAWPAYLOAD;
  assign dnWPAYLOAD  = upWPAYLOAD;
  assign dnWLAST     = upWLAST;
  assign upBPAYLOAD  = dnBPAYLOAD;
  assign dnARPAYLOAD = upARPAYLOAD;
  assign upRPAYLOAD  = dnRPAYLOAD;
  assign upRLAST     = dnRLAST;

  // Handshake signals are forced low while reset is held.
  assign dnAWVALID = sysReset & upAWVALID & aw_ok_s;
  assign upAWREADY = sysReset & dnAWREADY & aw_ok_s;
  assign dnWVALID  = sysReset & upWVALID & w_ok_s;
  assign upWREADY  = sysReset & dnWREADY & w_ok_s;
  assign upBVALID  = sysReset & dnBVALID;
  assign dnBREADY  = sysReset & upBREADY;
  assign dnARVALID = sysReset & upARVALID & ar_ok_s;
  assign upARREADY = sysReset & dnARREADY & ar_ok_s;
  assign upRVALID  = sysReset & dnRVALID;
  assign dnRREADY  = sysReset & upRREADY;

  assign aw_hs_s     = dnAWVALID & dnAWREADY;
  assign w_last_hs_s = dnWVALID & dnWREADY & upWLAST;
  assign b_hs_s      = upBVALID & upBREADY;
  assign ar_hs_s     = dnARVALID & dnARREADY;
  assign r_last_hs_s = upRVALID & upRREADY & dnRLAST;

  // Next-state values of the three transaction counters.
  always_comb begin
    wr_cnt_d  = cnt_next(wr_cnt_q, aw_hs_s, b_hs_s);
    aw_pend_d = cnt_next(aw_pend_q, aw_hs_s, w_last_hs_s);
    rd_cnt_d  = cnt_next(rd_cnt_q, ar_hs_s, r_last_hs_s);
  end

  // Counter registers.
  always_ff @(posedge SLV_CLK) begin
    if (!sysReset) begin
      wr_cnt_q  <= 8'd0;
      aw_pend_q <= 8'd0;
      rd_cnt_q  <= 8'd0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      aw_pend_q <= aw_pend_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Drain FSM with registered acknowledge; a dropped request always returns to RUN.
  always_ff @(posedge SLV_CLK) begin
    if (!sysReset) begin
      state_q     <= ST_RUN;
      drain_ack_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          state_q     <= DRAIN_REQ ? ST_DRAIN : ST_RUN;
          drain_ack_q <= 1'b0;
        end
        ST_DRAIN: begin
          if (!DRAIN_REQ) begin
            state_q     <= ST_RUN;
            drain_ack_q <= 1'b0;
          end else if (idle_s) begin
            state_q     <= ST_QUIESCED;
            drain_ack_q <= 1'b1;
          end else begin
            state_q     <= ST_DRAIN;
            drain_ack_q <= 1'b0;
          end
        end
        ST_QUIESCED: begin
          if (!DRAIN_REQ) begin
            state_q     <= ST_RUN;
            drain_ack_q <= 1'b0;
          end else begin
            state_q     <= ST_QUIESCED;
            drain_ack_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          drain_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign DRAIN_ACK = drain_ack_q;

`ifdef SLV_TXN_LIMIT_STATS_EN
  logic err_q;
  logic underflow_s;

  function automatic logic is_underflow(input logic [7:0] cnt, input logic inc, input logic dec);
    return dec && !inc && (cnt == 8'd0);
  endfunction

  assign underflow_s = is_underflow(wr_cnt_q, aw_hs_s, b_hs_s)
                     | is_underflow(aw_pend_q, aw_hs_s, w_last_hs_s)
                     | is_underflow(rd_cnt_q, ar_hs_s, r_last_hs_s);

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge SLV_CLK) begin
    if (!sysReset) begin
      err_q <= 1'b0;
    end else if (underflow_s) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign STAT_WRCNT = wr_cnt_q;
  assign STAT_RDCNT = rd_cnt_q;
  assign STAT_ERR   = err_q;
`else
  assign STAT_WRCNT = 8'd0;
  assign STAT_RDCNT = 8'd0;
  assign STAT_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_slv_outstanding_txn_limiter.sv
// Scoreboard bench for slv_outstanding_txn_limiter: payload queues checked at the slave side,
// gating and counter behaviour checked against fixed expectations per scenario.
module tb_slv_outstanding_txn_limiter;

  logic SLV_CLK = 1'b0;
  logic sysReset, DRAIN_REQ, DRAIN_ACK;
  logic [63:0] upAWPAYLOAD, dnAWPAYLOAD, upARPAYLOAD, dnARPAYLOAD;
  logic upAWVALID, upAWREADY, dnAWVALID, dnAWREADY;
  logic [36:0] upWPAYLOAD, dnWPAYLOAD;
  logic upWLAST, upWVALID, upWREADY, dnWLAST, dnWVALID, dnWREADY;
  logic [2:0] dnBPAYLOAD, upBPAYLOAD;
  logic dnBVALID, dnBREADY, upBVALID, upBREADY;
  logic upARVALID, upARREADY, dnARVALID, dnARREADY;
  logic [37:0] dnRPAYLOAD, upRPAYLOAD;
  logic dnRLAST, dnRVALID, dnRREADY, upRLAST, upRVALID, upRREADY;
  logic [7:0] STAT_WRCNT, STAT_RDCNT;
  logic STAT_ERR;

`ifdef SLV_TXN_LIMIT_STATS_EN
  localparam logic [63:0] EXP_ERR = 64'd1;
`else
  localparam logic [63:0] EXP_ERR = 64'd0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] aw_q[$];
  logic [63:0] w_q[$];
  logic [63:0] ar_q[$];

  slv_outstanding_txn_limiter dut (
    .SLV_CLK(SLV_CLK), .sysReset(sysReset), .DRAIN_REQ(DRAIN_REQ), .DRAIN_ACK(DRAIN_ACK),
    .upAWPAYLOAD(upAWPAYLOAD), .upAWVALID(upAWVALID), .upAWREADY(upAWREADY),
    .dnAWPAYLOAD(dnAWPAYLOAD), .dnAWVALID(dnAWVALID), .dnAWREADY(dnAWREADY),
    .upWPAYLOAD(upWPAYLOAD), .upWLAST(upWLAST), .upWVALID(upWVALID), .upWREADY(upWREADY),
    .dnWPAYLOAD(dnWPAYLOAD), .dnWLAST(dnWLAST), .dnWVALID(dnWVALID), .dnWREADY(dnWREADY),
    .dnBPAYLOAD(dnBPAYLOAD), .dnBVALID(dnBVALID), .dnBREADY(dnBREADY),
    .upBPAYLOAD(upBPAYLOAD), .upBVALID(upBVALID), .upBREADY(upBREADY),
    .upARPAYLOAD(upARPAYLOAD), .upARVALID(upARVALID), .upARREADY(upARREADY),
    .dnARPAYLOAD(dnARPAYLOAD), .dnARVALID(dnARVALID), .dnARREADY(dnARREADY),
    .dnRPAYLOAD(dnRPAYLOAD), .dnRLAST(dnRLAST), .dnRVALID(dnRVALID), .dnRREADY(dnRREADY),
    .upRPAYLOAD(upRPAYLOAD), .upRLAST(upRLAST), .upRVALID(upRVALID), .upRREADY(upRREADY),
    .STAT_WRCNT(STAT_WRCNT), .STAT_RDCNT(STAT_RDCNT), .STAT_ERR(STAT_ERR)
  );

  always #5 SLV_CLK = ~SLV_CLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SLV_CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge SLV_CLK);
  endtask

  task automatic idle_inputs();
    DRAIN_REQ = 1'b0;
    upAWVALID = 1'b0; upAWPAYLOAD = 64'd0; dnAWREADY = 1'b1;
    upWVALID = 1'b0; upWLAST = 1'b0; upWPAYLOAD = 37'd0; dnWREADY = 1'b1;
    dnBVALID = 1'b0; dnBPAYLOAD = 3'd0; upBREADY = 1'b1;
    upARVALID = 1'b0; upARPAYLOAD = 64'd0; dnARREADY = 1'b1;
    dnRVALID = 1'b0; dnRLAST = 1'b0; dnRPAYLOAD = 38'd0; upRREADY = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    sysReset = 1'b0;
    tick();
    tick();
    sysReset = 1'b1;
  endtask

  task automatic send_aw(input logic [63:0] p);
    upAWVALID = 1'b1;
    upAWPAYLOAD = p;
    aw_q.push_back(p);
    tick();
    upAWVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [63:0] p);
    upARVALID = 1'b1;
    upARPAYLOAD = p;
    ar_q.push_back(p);
    tick();
    upARVALID = 1'b0;
  endtask

  // Slave-side scoreboard: every accepted beat must match the oldest expected one.
  always @(negedge SLV_CLK) begin
    if (dnAWVALID && dnAWREADY) begin
      if (aw_q.size() == 0) check_eq("aw_unexpected", 64'd1, 64'd0);
      else check_eq("aw_payload", dnAWPAYLOAD, aw_q.pop_front());
    end
    if (dnWVALID && dnWREADY) begin
      if (w_q.size() == 0) check_eq("w_unexpected", 64'd1, 64'd0);
      else check_eq("w_beat", 64'({dnWLAST, dnWPAYLOAD}), w_q.pop_front());
    end
    if (dnARVALID && dnARREADY) begin
      if (ar_q.size() == 0) check_eq("ar_unexpected", 64'd1, 64'd0);
      else check_eq("ar_payload", dnARPAYLOAD, ar_q.pop_front());
    end
  end

  initial begin
    idle_inputs();
    sysReset = 1'b0;
    tick();
    tick();
    sysReset = 1'b1;
    smp();
    check_eq("rst_wrcnt", 64'(dut.wr_cnt_q), 64'd0);
    check_eq("rst_ack", 64'(DRAIN_ACK), 64'd0);
    check_eq("rst_stat", 64'({STAT_WRCNT, STAT_RDCNT, STAT_ERR}), 64'd0);
    tick();

    // Write limit: four AWs accepted, the fifth waits for a B.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      upAWVALID = 1'b1;
      upAWPAYLOAD = 64'hA000 + 64'(i);
      aw_q.push_back(upAWPAYLOAD);
      smp();
      check_eq("awrdy_below_limit", 64'(upAWREADY), 64'd1);
      tick();
    end
    upAWPAYLOAD = 64'hA004;
    for (int i = 0; i < 2; i++) begin
      smp();
      check_eq("awrdy_at_limit", 64'({upAWREADY, dnAWVALID}), 64'd0);
      tick();
    end
    dnBVALID = 1'b1;
    dnBPAYLOAD = 3'd5;
    smp();
    check_eq("b_passthrough", 64'({upBVALID, upBPAYLOAD, dnBREADY}), 64'({1'b1, 3'd5, 1'b1}));
    check_eq("awrdy_during_b", 64'(upAWREADY), 64'd0);
    tick();
    dnBVALID = 1'b0;
    aw_q.push_back(64'hA004);
    smp();
    check_eq("awrdy_after_b", 64'(upAWREADY), 64'd1);
    tick();
    upAWVALID = 1'b0;
    smp();
    check_eq("wrcnt_refill", 64'(dut.wr_cnt_q), 64'd4);
    tick();

    // W ordering: W held until its AW has been issued.
    do_reset();
    upWVALID = 1'b1;
    upWPAYLOAD = 37'h1;
    smp();
    check_eq("w_blocked_no_aw", 64'({dnWVALID, upWREADY}), 64'd0);
    tick();
    upAWVALID = 1'b1;
    upAWPAYLOAD = 64'hB0;
    aw_q.push_back(64'hB0);
    smp();
    check_eq("w_blocked_aw_cycle", 64'(dnWVALID), 64'd0);
    tick();
    upAWVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      upWPAYLOAD = 37'h100 + 37'(i);
      upWLAST = (i == 3);
      w_q.push_back(64'({upWLAST, upWPAYLOAD}));
      smp();
      check_eq("w_ready_after_aw", 64'({dnWVALID, upWREADY}), 64'd3);
      tick();
    end
    upWLAST = 1'b0;
    smp();
    check_eq("w_blocked_after_last", 64'(dnWVALID), 64'd0);
    check_eq("awpend_zero", 64'(dut.aw_pend_q), 64'd0);
    tick();
    upWVALID = 1'b0;

    // Simultaneous increment and decrement.
    do_reset();
    send_aw(64'hC0);
    send_aw(64'hC1);
    upAWVALID = 1'b1;
    upAWPAYLOAD = 64'hC2;
    aw_q.push_back(64'hC2);
    dnBVALID = 1'b1;
    smp();
    check_eq("aw_with_b", 64'(upAWREADY), 64'd1);
    tick();
    upAWVALID = 1'b0;
    dnBVALID = 1'b0;
    smp();
    check_eq("wrcnt_same_cycle", 64'(dut.wr_cnt_q), 64'd2);
    tick();
    send_ar(64'hD0);
    upARVALID = 1'b1;
    upARPAYLOAD = 64'hD1;
    ar_q.push_back(64'hD1);
    dnRVALID = 1'b1;
    dnRLAST = 1'b1;
    dnRPAYLOAD = 38'h2A;
    smp();
    check_eq("r_passthrough", 64'({upRVALID, upRLAST, upRPAYLOAD, dnRREADY}),
             64'({1'b1, 1'b1, 38'h2A, 1'b1}));
    tick();
    idle_inputs();
    smp();
    check_eq("rdcnt_same_cycle", 64'(dut.rd_cnt_q), 64'd1);
`ifdef SLV_TXN_LIMIT_STATS_EN
    check_eq("stat_counts", 64'({STAT_WRCNT, STAT_RDCNT}), 64'({8'd2, 8'd1}));
`endif
    tick();

    // Drain handshake with three reads outstanding.
    do_reset();
    send_ar(64'hE0);
    send_ar(64'hE1);
    send_ar(64'hE2);
    DRAIN_REQ = 1'b1;
    upAWVALID = 1'b1;
    upAWPAYLOAD = 64'hE8;
    aw_q.push_back(64'hE8);
    smp();
    check_eq("aw_on_drain_edge", 64'(upAWREADY), 64'd1);
    tick();
    upAWVALID = 1'b0;
    upARVALID = 1'b1;
    upARPAYLOAD = 64'hE3;
    smp();
    check_eq("ar_blocked_drain", 64'({upARREADY, dnARVALID}), 64'd0);
    check_eq("wrcnt_drain_edge", 64'(dut.wr_cnt_q), 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      dnRVALID = 1'b1;
      dnRLAST = 1'b1;
      upWVALID = (i == 0);
      upWLAST = (i == 0);
      dnBVALID = (i == 0);
      upWPAYLOAD = 37'h77;
      if (i == 0) w_q.push_back(64'({1'b1, 37'h77}));
      smp();
      if (i == 0) check_eq("w_during_drain", 64'(upWREADY), 64'd1);
      tick();
    end
    dnRVALID = 1'b0;
    dnRLAST = 1'b0;
    upWVALID = 1'b0;
    upWLAST = 1'b0;
    dnBVALID = 1'b0;
    smp();
    check_eq("ack_not_yet", 64'(DRAIN_ACK), 64'd0);
    tick();
    smp();
    check_eq("ack_quiesced", 64'(DRAIN_ACK), 64'd1);
    check_eq("ar_blocked_quiesced", 64'(upARREADY), 64'd0);
    tick();
    DRAIN_REQ = 1'b0;
    tick();
    ar_q.push_back(64'hE3);
    smp();
    check_eq("ack_release", 64'(DRAIN_ACK), 64'd0);
    check_eq("ar_resumed", 64'(upARREADY), 64'd1);
    tick();
    upARVALID = 1'b0;

    // Spurious B at zero count.
    do_reset();
    dnBVALID = 1'b1;
    smp();
    check_eq("spurious_b_ready", 64'(dnBREADY), 64'd1);
    tick();
    dnBVALID = 1'b0;
    smp();
    check_eq("wrcnt_underflow_hold", 64'(dut.wr_cnt_q), 64'd0);
    check_eq("stat_err", 64'(STAT_ERR), EXP_ERR);
    tick();

    // Reset in the middle of traffic.
    do_reset();
    send_aw(64'hF0);
    send_aw(64'hF1);
    send_aw(64'hF2);
    upWVALID = 1'b1;
    upAWVALID = 1'b1;
    dnBVALID = 1'b1;
    upARVALID = 1'b1;
    dnRVALID = 1'b1;
    sysReset = 1'b0;
    smp();
    check_eq("rst_gates_outputs",
             64'({upAWREADY, dnAWVALID, upWREADY, dnWVALID, dnBREADY, upBVALID,
                  upARREADY, dnARVALID, dnRREADY, upRVALID}), 64'd0);
    tick();
    tick();
    sysReset = 1'b1;
    idle_inputs();
    upAWVALID = 1'b1;
    upAWPAYLOAD = 64'hF9;
    aw_q.push_back(64'hF9);
    smp();
    check_eq("rst_counters", 64'({dut.wr_cnt_q, dut.rd_cnt_q, dut.aw_pend_q}), 64'd0);
    check_eq("rst_run_state", 64'({upAWREADY, DRAIN_ACK}), 64'({1'b1, 1'b0}));
    tick();
    idle_inputs();
    tick();

    check_eq("aw_q_drained", 64'(aw_q.size()), 64'd0);
    check_eq("w_q_drained", 64'(w_q.size()), 64'd0);
    check_eq("ar_q_drained", 64'(ar_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
